// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: oversampling receiver for the 4-wire LCD serial bus, feeding a FWFT {dc, byte} FIFO.
// Define LCD_RX_PIXCNT_EN to enable the RAMWR data-byte counter on pix_bytes (tied to 0 otherwise).
module lcd_spi_rx #(
    parameter  int FIFO_DEPTH = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lcd_clk_in,
    input  logic          lcd_data_in,
    input  logic          lcd_cs_n_in,
    input  logic          lcd_dc_in,
    input  logic          rx_ready,
    output logic          rx_valid,
    output logic [7:0]    rx_data,
    output logic          rx_dc,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic          frame_err,
    output logic          frame_active,
    output logic [23:0]   pix_bytes
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    logic cs_s1_q, cs_s2_q;
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic dat_s1_q, dat_s2_q;
    logic dc_s1_q, dc_s2_q;
    logic sclk_rise;

    // NOTE: registers are updated with <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_s1_q  <= 1'b1;
            cs_s2_q  <= 1'b1;
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_s3_q <= 1'b0;
            dat_s1_q <= 1'b0;
            dat_s2_q <= 1'b0;
            dc_s1_q  <= 1'b0;
            dc_s2_q  <= 1'b0;
        end else begin
            cs_s1_q  <= lcd_cs_n_in;
            cs_s2_q  <= cs_s1_q;
            sck_s1_q <= lcd_clk_in;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            dat_s1_q <= lcd_data_in;
            dat_s2_q <= dat_s1_q;
            dc_s1_q  <= lcd_dc_in;
            dc_s2_q  <= dc_s1_q;
        end
    end

    assign sclk_rise = sck_s2_q & ~sck_s3_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] sh_q, sh_d;
    logic [7:0] byte_q, byte_d;
    logic       bdc_q, bdc_d;
    logic       cap_q, cap_d;
    logic       push_q;
    logic       frame_err_q, frame_err_d;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        byte_d      = byte_q;
        bdc_d       = bdc_q;
        cap_d       = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (!cs_s2_q) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    sh_d = {sh_q[5:0], dat_s2_q};
                    if (bit_cnt_q == 3'd7) begin
                        byte_d    = {sh_q, dat_s2_q};
                        bdc_d     = dc_s2_q;
                        cap_d     = 1'b1;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // A byte completing on the same cycle cs_n rises is kept without error.
                if (cs_s2_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = !cap_d && (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            sh_q        <= 7'd0;
            byte_q      <= 8'd0;
            bdc_q       <= 1'b0;
            cap_q       <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            byte_q      <= byte_d;
            bdc_q       <= bdc_d;
            cap_q       <= cap_d;
            push_q      <= cap_q;
            frame_err_q <= frame_err_d;
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rx_valid_q, overflow_q, overflow_d;
    logic [8:0]    head_q, head_d;
    logic          full, pop, push_ok;
    logic [8:0]    push_word;

    assign push_word = {bdc_q, byte_q};
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign pop       = rx_valid_q & rx_ready;
    assign push_ok   = push_q & (~full | pop);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        if (pop && !push_ok) count_d = count_q - CW'(1);
        overflow_d = overflow_q | (push_q & full & ~pop);
        // The incoming word bypasses storage when it becomes the new head.
        head_d = 9'd0;
        if (count_d != '0) begin
            if (push_ok && wr_ptr_q == rd_ptr_d) head_d = push_word;
            else head_d = mem[rd_ptr_d];
        end
    end

    // NOTE: storage is not reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (rst && push_ok) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_valid_q <= 1'b0;
            head_q     <= 9'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_valid_q <= (count_d != '0);
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef LCD_RX_PIXCNT_EN
    logic        armed_q, armed_d;
    logic [23:0] pix_q, pix_d;

    always_comb begin
        armed_d = armed_q;
        pix_d   = pix_q;
        if (cap_d) begin
            if (!bdc_d) begin
                armed_d = (byte_d == 8'h2C);
                if (byte_d == 8'h2C) pix_d = 24'd0;
            end else if (armed_q && pix_q != 24'hFF_FFFF) begin
                pix_d = pix_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_q <= 1'b0;
            pix_q   <= 24'd0;
        end else begin
            armed_q <= armed_d;
            pix_q   <= pix_d;
        end
    end

    assign pix_bytes = pix_q;
`else
    assign pix_bytes = 24'd0;
`endif

    assign rx_valid     = rx_valid_q;
    assign rx_data      = head_q[7:0];
    assign rx_dc        = head_q[8];
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;
    assign frame_active = ~cs_s2_q;

endmodule
